// File: rtl/edid_seg_slave.sv
// E-DDC EDID slave serving one of NUM_IMAGES multi-block images from a host-loaded RAM.
// Define EDID_SEG_EN to build the segment pointer at SEG_ADDR; otherwise SEG_ADDR is NACKed.
module edid_seg_slave #(
  parameter logic [6:0] DEV_ADDR   = 7'h50,
  parameter logic [6:0] SEG_ADDR   = 7'h30,
  parameter int         NUM_BLOCKS = 2,
  parameter int         NUM_IMAGES = 2,
  parameter int         FILTER_LEN = 4,
  localparam int        LD_AW      = $clog2(NUM_IMAGES * NUM_BLOCKS * 128),
  localparam int        IS_W       = (NUM_IMAGES > 1) ? $clog2(NUM_IMAGES) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             scl,
  input  logic             sda_in,
  output logic             sda_out,
  input  logic [IS_W-1:0]  image_sel,
  input  logic             ld_we,
  input  logic [LD_AW-1:0] ld_addr,
  input  logic [7:0]       ld_data,
  output logic             busy
);

`ifdef EDID_SEG_EN
  localparam bit SEG_EN = 1'b1;
`else
  localparam bit SEG_EN = 1'b0;
`endif

  localparam int         IMG_BYTES = NUM_BLOCKS * 128;
  localparam int         RAM_DEPTH = NUM_IMAGES * IMG_BYTES;
  localparam int         FC_W      = $clog2(FILTER_LEN + 1);
  localparam logic [7:0] DEV_WR    = {DEV_ADDR, 1'b0};
  localparam logic [7:0] DEV_RD    = {DEV_ADDR, 1'b1};
  localparam logic [7:0] SEG_WR    = {SEG_ADDR, 1'b0};

  typedef enum logic [2:0] {
    ST_IDLE, ST_ADDR, ST_OFFSET, ST_SEG, ST_ACK, ST_WAIT, ST_RD_BYTE, ST_RD_ACK
  } state_e;

  // Bit 0 carries SCL, bit 1 carries SDA through synchroniser and glitch filter.
  logic [1:0]      sync1_q, sync2_q, filt_q, filt_p_q;
  logic [FC_W-1:0] fcnt_q [2];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 2'b11;
      sync2_q  <= 2'b11;
      filt_q   <= 2'b11;
      filt_p_q <= 2'b11;
      for (int i = 0; i < 2; i++) fcnt_q[i] <= '0;
    end else begin
      sync1_q  <= {sda_in, scl};
      sync2_q  <= sync1_q;
      filt_p_q <= filt_q;
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] == filt_q[i]) begin
          fcnt_q[i] <= '0;
        end else if (fcnt_q[i] == FC_W'(FILTER_LEN - 1)) begin
          filt_q[i] <= sync2_q[i];
          fcnt_q[i] <= '0;
        end else begin
          fcnt_q[i] <= fcnt_q[i] + 1'b1;
        end
      end
    end
  end

  logic scl_f, sda_f, scl_p, sda_p;
  logic scl_rise, scl_fall, start_c, stop_c;
  assign scl_f    = filt_q[0];
  assign sda_f    = filt_q[1];
  assign scl_p    = filt_p_q[0];
  assign sda_p    = filt_p_q[1];
  assign scl_rise = scl_f & ~scl_p;
  assign scl_fall = ~scl_f & scl_p;
  assign start_c  = scl_f & scl_p & sda_p & ~sda_f;
  assign stop_c   = scl_f & scl_p & ~sda_p & sda_f;

  state_e          state_q, state_d, ret_q, ret_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [7:0]      shift_q, shift_d, offset_q, offset_d, seg_q, seg_d;
  logic [IS_W-1:0] img_q, img_d;
  logic            sda_q, sda_d, busy_q, busy_d;

  // Image RAM: load port from the host, registered read port for the DDC side.
  logic [7:0]       mem_q [RAM_DEPTH];
  logic [7:0]       rd_data_q, byte_data;
  logic [15:0]      byte_addr;
  logic [LD_AW-1:0] rd_addr;
  logic             rd_ok, rd_ok_q;

  assign byte_addr = {(SEG_EN ? seg_q : 8'h00), offset_q};
  assign rd_ok     = (int'(img_q) < NUM_IMAGES) && (int'(byte_addr) < IMG_BYTES);
  assign rd_addr   = LD_AW'(int'(img_q) * IMG_BYTES + int'(byte_addr));
  assign byte_data = rd_ok_q ? rd_data_q : 8'hFF;

  // NOTE: the RAM has no reset; firmware reloads it and a reset would prevent RAM inference.
  always_ff @(posedge clk) begin
    if (ld_we && int'(ld_addr) < RAM_DEPTH) mem_q[ld_addr] <= ld_data;
    if (rd_ok) rd_data_q <= mem_q[rd_addr];
  end

  logic rx_state, byte_done;
  assign rx_state  = state_q inside {ST_ADDR, ST_OFFSET, ST_SEG, ST_WAIT};
  assign byte_done = scl_fall && (cnt_q == 4'd8);

  // NOTE: every next-state signal gets a default first so no path leaves a latch behind.
  always_comb begin
    state_d  = state_q;
    ret_d    = ret_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    offset_d = offset_q;
    seg_d    = seg_q;
    img_d    = img_q;
    sda_d    = sda_q;
    busy_d   = busy_q;
    if (stop_c) begin
      state_d = ST_IDLE;
      busy_d  = 1'b0;
      seg_d   = '0;
    end else if (start_c) begin
      state_d = ST_ADDR;
      cnt_d   = '0;
      img_d   = image_sel;
    end else begin
      if (rx_state && scl_rise && cnt_q != 4'd8) begin
        shift_d = {shift_q[6:0], sda_f};
        cnt_d   = cnt_q + 4'd1;
      end
      unique case (state_q)
        ST_ADDR: if (byte_done) begin
          cnt_d   = '0;
          state_d = ST_ACK;
          sda_d   = 1'b0;
          busy_d  = 1'b1;
          if (shift_q == DEV_WR)                ret_d = ST_OFFSET;
          else if (shift_q == DEV_RD)           ret_d = ST_RD_BYTE;
          else if (SEG_EN && shift_q == SEG_WR) ret_d = ST_SEG;
          else begin
            state_d = ST_IDLE;
            sda_d   = 1'b1;
            busy_d  = 1'b0;
          end
        end
        ST_OFFSET, ST_SEG: if (byte_done) begin
          if (state_q == ST_OFFSET) offset_d = shift_q;
          else                      seg_d    = shift_q;
          cnt_d   = '0;
          sda_d   = 1'b0;
          ret_d   = ST_WAIT;
          state_d = ST_ACK;
        end
        // Only a repeated START is expected here; a further data byte is left unacknowledged.
        ST_WAIT: if (byte_done) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
        ST_ACK: if (scl_fall) begin
          state_d = ret_q;
          if (ret_q == ST_RD_BYTE) begin
            shift_d = byte_data;
            sda_d   = byte_data[7];
            cnt_d   = 4'd1;
          end else begin
            sda_d = 1'b1;
            cnt_d = '0;
          end
        end
        ST_RD_BYTE: if (scl_fall) begin
          if (cnt_q == 4'd8) begin
            sda_d   = 1'b1;
            cnt_d   = '0;
            state_d = ST_RD_ACK;
          end else begin
            sda_d   = shift_q[6];
            shift_d = {shift_q[6:0], 1'b0};
            cnt_d   = cnt_q + 4'd1;
          end
        end
        ST_RD_ACK: begin
          if (scl_rise) begin
            if (!sda_f) begin
              offset_d = offset_q + 8'd1;
            end else begin
              state_d = ST_IDLE;
              busy_d  = 1'b0;
              seg_d   = '0;
            end
          end else if (scl_fall) begin
            shift_d = byte_data;
            sda_d   = byte_data[7];
            cnt_d   = 4'd1;
            state_d = ST_RD_BYTE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      ret_q    <= ST_IDLE;
      cnt_q    <= '0;
      shift_q  <= '0;
      offset_q <= '0;
      seg_q    <= '0;
      img_q    <= '0;
      sda_q    <= 1'b1;
      busy_q   <= 1'b0;
      rd_ok_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ret_q    <= ret_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      offset_q <= offset_d;
      seg_q    <= seg_d;
      img_q    <= img_d;
      sda_q    <= sda_d;
      busy_q   <= busy_d;
      rd_ok_q  <= rd_ok;
    end
  end

  assign sda_out = sda_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_edid_seg_slave.sv
// Directed bench for edid_seg_slave: bus-level master, wired-AND SDA, hand-computed EDID bytes.
module tb_edid_seg_slave;
`ifdef EDID_SEG_EN
  localparam int NB = 4;
`else
  localparam int NB = 2;
`endif
  localparam int IMG = NB * 128;
  localparam int AW  = $clog2(2 * IMG);
  localparam int Q   = 150;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          scl = 1'b1;
  logic          sda_m = 1'b1;
  logic [0:0]    image_sel = 1'b0;
  logic          ld_we = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [7:0]    ld_data = '0;
  logic          sda_out, busy, sda_bus;
  int            errors = 0;
  int            checks = 0;
  int            low_cnt = 0;

  assign sda_bus = sda_m & sda_out;

  edid_seg_slave #(.NUM_BLOCKS(NB), .NUM_IMAGES(2), .FILTER_LEN(4)) dut (
    .clk(clk), .rst_n(rst_n), .scl(scl), .sda_in(sda_bus), .sda_out(sda_out),
    .image_sel(image_sel), .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (sda_out === 1'b0) low_cnt++;

  // Image contents: byte a of image 0 is a[7:0] plus 0x11 per 256-byte segment; image 1 is inverted.
  function automatic logic [7:0] pat(input int img, input int a);
    logic [7:0] d;
    if (a >= IMG) return 8'hFF;
    d = 8'(a) + 8'(a / 256) * 8'h11;
    return (img == 1) ? ~d : d;
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic load_ram();
    @(negedge clk);
    for (int img = 0; img < 2; img++) begin
      for (int a = 0; a < IMG; a++) begin
        ld_we = 1'b1; ld_addr = AW'(img * IMG + a); ld_data = pat(img, a);
        @(negedge clk);
      end
    end
    ld_we = 1'b0;
  endtask

  task automatic bus_start();
    sda_m = 1'b1; #(Q); scl = 1'b1; #(Q); sda_m = 1'b0; #(Q); scl = 1'b0; #(Q);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; #(Q); scl = 1'b1; #(Q); sda_m = 1'b1; #(Q);
  endtask

  task automatic clock_bit(input logic b, output logic s);
    sda_m = b; #(Q); scl = 1'b1; #(Q); s = sda_bus; #(Q); scl = 1'b0; #(Q);
  endtask

  task automatic wr(input logic [7:0] b, input string tag, input logic exp_ack);
    logic s, ack;
    for (int i = 7; i >= 0; i--) clock_bit(b[i], s);
    clock_bit(1'b1, ack);
    check(tag, 8'(ack), 8'(exp_ack));
  endtask

  task automatic rd(input logic nack, input string tag, input logic [7:0] exp);
    logic s;
    logic [7:0] b;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, s);
      b[i] = s;
    end
    clock_bit(nack, s);
    check(tag, b, exp);
  endtask

  initial begin
    int l0;
    @(negedge clk); rst_n = 1'b0;
    #20;
    check("rst_sda_out", 8'(sda_out), 8'h01);
    check("rst_busy", 8'(busy), 8'h00);
    @(negedge clk); rst_n = 1'b1;
    load_ram();

    // Offset write, repeated START, sequential read of image 0.
    image_sel = 1'b0;
    bus_start(); wr(8'hA0, "t1_dev_wr_ack", 1'b0);
    check("t1_busy_after_ack", 8'(busy), 8'h01);
    wr(8'h10, "t1_ofs_ack", 1'b0);
    bus_start(); wr(8'hA1, "t1_dev_rd_ack", 1'b0);
    rd(1'b0, "t1_d10", 8'h10); rd(1'b0, "t1_d11", 8'h11); rd(1'b0, "t1_d12", 8'h12);
    check("t1_busy_mid_read", 8'(busy), 8'h01);
    rd(1'b1, "t1_d13", 8'h13);
    bus_stop();
    check("t1_busy_after_stop", 8'(busy), 8'h00);
    check("t1_sda_released", 8'(sda_out), 8'h01);

    // Image 1, with image_sel toggled during the read: latched value must hold.
    image_sel = 1'b1;
    bus_start(); wr(8'hA0, "t2_dev_wr_ack", 1'b0); wr(8'h00, "t2_ofs_ack", 1'b0);
    bus_start(); wr(8'hA1, "t2_dev_rd_ack", 1'b0);
    image_sel = 1'b0;
    rd(1'b0, "t2_img1_d0", 8'hFF);
    image_sel = 1'b1; #(Q); image_sel = 1'b0;
    rd(1'b1, "t2_img1_d1", 8'hFE);
    bus_stop();

`ifdef EDID_SEG_EN
    bus_start(); wr(8'h60, "s_seg_addr_ack", 1'b0); wr(8'h01, "s_seg_val_ack", 1'b0);
    bus_start(); wr(8'hA0, "s_dev_wr_ack", 1'b0); wr(8'h80, "s_ofs_ack", 1'b0);
    bus_start(); wr(8'hA1, "s_dev_rd_ack", 1'b0);
    rd(1'b0, "s_d180", pat(0, 'h180)); rd(1'b1, "s_d181", pat(0, 'h181));
    bus_stop();
    bus_start(); wr(8'hA0, "s_dev_wr2_ack", 1'b0); wr(8'h00, "s_ofs2_ack", 1'b0);
    bus_start(); wr(8'hA1, "s_dev_rd2_ack", 1'b0);
    rd(1'b1, "s_seg_reset_d000", pat(0, 'h000));
    bus_stop();
    bus_start(); wr(8'h60, "s_seg2_addr_ack", 1'b0); wr(8'h02, "s_seg2_val_ack", 1'b0);
    bus_start(); wr(8'hA0, "s_dev_wr3_ack", 1'b0); wr(8'h00, "s_ofs3_ack", 1'b0);
    bus_start(); wr(8'hA1, "s_dev_rd3_ack", 1'b0);
    rd(1'b1, "s_seg2_oob", 8'hFF);
    bus_stop();
    bus_start(); wr(8'h60, "w_seg_addr_ack", 1'b0); wr(8'h01, "w_seg_val_ack", 1'b0);
    bus_start(); wr(8'hA0, "w_dev_wr_ack", 1'b0); wr(8'hFF, "w_ofs_ack", 1'b0);
    bus_start(); wr(8'hA1, "w_dev_rd_ack", 1'b0);
    rd(1'b0, "w_d1ff", pat(0, 'h1FF)); rd(1'b1, "w_wrap_d100", pat(0, 'h100));
    bus_stop();
`else
    bus_start(); wr(8'h60, "seg_addr_nack", 1'b1);
    check("seg_nack_busy", 8'(busy), 8'h00);
    bus_stop();
    bus_start(); wr(8'hA0, "w_dev_wr_ack", 1'b0); wr(8'hFF, "w_ofs_ack", 1'b0);
    bus_start(); wr(8'hA1, "w_dev_rd_ack", 1'b0);
    rd(1'b0, "w_dff", 8'hFF); rd(1'b1, "w_wrap_d00", 8'h00);
    bus_stop();
`endif

    // Foreign address 0x52: never acknowledged, SDA never pulled low.
    l0 = low_cnt;
    bus_start(); wr(8'hA4, "x52_addr_nack", 1'b1); wr(8'h55, "x52_data_nack", 1'b1);
    bus_stop();
    check("x52_sda_low_cycles", 8'(low_cnt - l0), 8'h00);

    // Second data byte after the offset is NACKed and closes the transaction.
    bus_start(); wr(8'hA0, "t5_dev_wr_ack", 1'b0); wr(8'h20, "t5_ofs_ack", 1'b0);
    wr(8'h33, "t5_extra_nack", 1'b1);
    check("t5_busy_after_nack", 8'(busy), 8'h00);
    bus_stop();

    // Two-cycle SCL glitch before the offset byte must not be counted as a bit.
    bus_start(); wr(8'hA0, "g_dev_wr_ack", 1'b0);
    scl = 1'b1; #20; scl = 1'b0; #(Q);
    wr(8'h05, "g_ofs_ack", 1'b0);
    bus_start(); wr(8'hA1, "g_dev_rd_ack", 1'b0);
    rd(1'b1, "g_d05", 8'h05);
    bus_stop();

    // Reset while the slave is driving a zero bit of a read.
    bus_start(); wr(8'hA0, "r_dev_wr_ack", 1'b0); wr(8'h00, "r_ofs_ack", 1'b0);
    bus_start(); wr(8'hA1, "r_dev_rd_ack", 1'b0);
    check("r_driving_bit7", 8'(sda_out), 8'h00);
    rst_n = 1'b0;
    #1;
    check("r_sda_async_release", 8'(sda_out), 8'h01);
    check("r_busy_cleared", 8'(busy), 8'h00);
    #(Q - 1);
    rst_n = 1'b1;
    sda_m = 1'b1; scl = 1'b1;
    #(4 * Q);
    load_ram();
    bus_start(); wr(8'hA0, "r2_dev_wr_ack", 1'b0); wr(8'h42, "r2_ofs_ack", 1'b0);
    bus_start(); wr(8'hA1, "r2_dev_rd_ack", 1'b0);
    rd(1'b1, "r2_d42", pat(0, 'h42));
    bus_stop();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
